// File: rtl/hs_dest_ctrl_pkg.sv
// Shared types and constants for the destination-side req/ack handshake controller.
// HS_DEST_SYNC3_EN selects a 3-flop sreq synchronizer instead of 2.
package hs_dest_ctrl_pkg;

   localparam int unsigned HS_DATA_W = 30;
   localparam int unsigned ROW_MSB   = 29;
   localparam int unsigned ROW_LSB   = 12;
   localparam int unsigned KER_MSB   = 11;
   localparam int unsigned KER_LSB   = 0;

`ifdef HS_DEST_SYNC3_EN
   localparam int unsigned HS_SYNC_STAGES = 3;
`else
   localparam int unsigned HS_SYNC_STAGES = 2;
`endif

   // {image row, kernel} word carried across the handshake
   typedef struct packed {
      logic [ROW_MSB-ROW_LSB:0] row;
      logic [KER_MSB-KER_LSB:0] kernel;
   } hs_word_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELIVER = 2'd1,
      ACK     = 2'd2
   } state_t;

   function automatic hs_word_t mk_word(input logic [ROW_MSB-ROW_LSB:0] row,
                                        input logic [KER_MSB-KER_LSB:0] kernel);
      hs_word_t w;
      w.row    = row;
      w.kernel = kernel;
      return w;
   endfunction

endpackage

// File: rtl/hs_dest_ctrl_if.sv
// Handshake and data signals between the source domain, this controller and its consumer.
interface hs_dest_ctrl_if;
   import hs_dest_ctrl_pkg::*;

   logic     sreq;
   hs_word_t din;
   logic     dbusy;
   logic     dvalid;
   hs_word_t dout;
   logic     dack;
   logic     idle;

   modport master (output sreq, din, dbusy, input dvalid, dout, dack, idle);
   modport slave  (input sreq, din, dbusy, output dvalid, dout, dack, idle);
endinterface

// File: rtl/ndff_sync.sv
// N-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module ndff_sync #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[DEPTH-2:0], d};
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/hs_dest_ctrl.sv
// Destination half of a four-phase req/ack handshake feeding the clk2 convolution engine.
// Define HS_DEST_SYNC3_EN for a 3-flop sreq synchronizer (default 2).
module hs_dest_ctrl
   import hs_dest_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   hs_dest_ctrl_if.slave  bus
);

   localparam int unsigned SYNC_STAGES = HS_SYNC_STAGES;

   logic     sreq_s;
   state_t   state_q, state_n;
   hs_word_t data_q,  data_n;
   hs_word_t dout_q,  dout_n;
   logic     dvalid_q, dvalid_n;
   logic     dack_q,   dack_n;

   ndff_sync #(.DEPTH(SYNC_STAGES)) u_sreq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.sreq),
      .q     (sreq_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         data_q   <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         dack_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         data_q   <= data_n;
         dout_q   <= dout_n;
         dvalid_q <= dvalid_n;
         dack_q   <= dack_n;
      end
   end

   // din is only sampled once sreq_s is seen, so it has been stable for SYNC_STAGES cycles
   always_comb begin
      state_n  = state_q;
      data_n   = data_q;
      dout_n   = dout_q;
      dvalid_n = 1'b0;
      dack_n   = dack_q;
      unique case (state_q)
         IDLE: begin
            dack_n = 1'b0;
            if (sreq_s) begin
               data_n  = bus.din;
               state_n = DELIVER;
            end
         end
         DELIVER: begin
            dack_n = 1'b0;
            if (!bus.dbusy) begin
               dvalid_n = 1'b1;
               dout_n   = data_q;
               dack_n   = 1'b1;
               state_n  = ACK;
            end
         end
         ACK: begin
            dack_n = 1'b1;
            if (!sreq_s) begin
               dack_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            dack_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   assign bus.dvalid = dvalid_q;
   assign bus.dout   = dout_q;
   assign bus.dack   = dack_q;
   // derived only from flops, so no input-to-output path
   assign bus.idle   = (state_q == IDLE) && !sreq_s;

endmodule

// File: doc/hs_dest_ctrl.md
Name: hs_dest_ctrl

Overview:
- Destination-domain half of the four-phase req/ack handshake. Sits directly upstream of the clk2 convolution engine.
- Synchronizes the source-domain request, captures the 30-bit {image row, kernel} word, and delivers it as a one-cycle valid pulse to the consumer.
- Returns an acknowledge to the source domain, then completes the four-phase return-to-zero.
- Fully single-clock; all cross-domain inputs are treated as asynchronous.

Parameters:
- DATA_W, 30, width of the transferred word: {row[17:0], kernel[11:0]}.
- SYNC_STAGES, 2, flip-flop depth of the sreq synchronizer; forced to 3 when HS_DEST_SYNC3_EN is defined.

Ports:
- clk  in  1  destination clock (clk2 domain).
- rst_n  in  1  asynchronous active-low reset.
- sreq  in  1  request from the source domain; asynchronous to clk.
- din  in  DATA_W  source data; the protocol requires it stable while sreq=1.
- dbusy  in  1  consumer cannot accept a word this cycle.
- dvalid  out  1  one-cycle pulse: dout carries a new word.
- dout  out  DATA_W  delivered word; holds its value between pulses.
- dack  out  1  acknowledge to the source domain.
- idle  out  1  state==IDLE and synchronized sreq==0.

Behaviour:
- Reset: clocking and reset are one clock, asynchronous active-low. All flops, including the synchronizer, clear. dvalid=0, dout=0, dack=0, state=IDLE, so idle=1 after reset.
- sreq_s is sreq passed through SYNC_STAGES flops. The FSM uses only sreq_s, never raw sreq.
- din is sampled only when sreq_s=1. By then din has been stable for at least SYNC_STAGES cycles, so it is not synchronized per bit.
- State IDLE:
  - dack=0.
  - If sreq_s=1: capture din into data_q, go to DELIVER.
- State DELIVER:
  - If dbusy=0: registered dvalid<=1, dout<=data_q, dack<=1, go to ACK.
  - If dbusy=1: stay in DELIVER with dvalid=0 and dack=0; the source stays stalled.
- State ACK:
  - dvalid<=0 on the next edge, and dack stays 1.
  - If sreq_s=0: dack<=0, go to IDLE.
  - If sreq_s stays 1: hold ACK indefinitely.
- All outputs are registered; there are no combinational paths from input to output.
- Latency, with SYNC_STAGES=2 and dbusy=0: sreq rise first sampled at edge E0, sreq_s=1 after E1, capture at E2, dvalid/dack rise at E3.
  - Minimum full transfer is 4 edges to dack rise plus 3 edges after sreq falls to dack fall.
  - Throughput is one word per ~10 clk2 cycles, excluding source-domain cycles.
- dvalid is exactly one cycle wide per transfer, and there is never more than one pulse per sreq high phase.
- Boundary conditions:
  - sreq drops during DELIVER (protocol violation): the captured word is still delivered. dack pulses high for exactly one cycle, then the FSM returns to IDLE.
  - dbusy asserted in the same cycle the FSM enters DELIVER: no pulse; delivery occurs on the first cycle with dbusy=0.
  - Back-to-back transfers: a new sreq rise is only recognized once the FSM is in IDLE, i.e. after dack has fallen.
  - Reset mid-transfer: dack drops asynchronously and any pending word is discarded.

Optional Feature:
- Macro HS_DEST_SYNC3_EN.
- Defined: a 3-flop sreq synchronizer (SYNC_STAGES=3). Every latency figure above grows by +1 edge on both the rise and fall paths.
- Undefined: a 2-flop synchronizer. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - HS_DATA_W=30.
  - Field slices ROW_MSB=29, ROW_LSB=12, KER_MSB=11, KER_LSB=0.
  - State enum {IDLE, DELIVER, ACK}.
- Sub-module ndff_sync (parameterized depth, async active-low reset, reset value 0) for sreq. It is reused later by the source-side controller for dack.

Test Plan:
- Reset, no stimulus: dvalid=0, dack=0, dout=0, idle=1 hold for 20 cycles; sreq glitch-free low produces no pulse.
- Single transfer: din=30'h2A5_5A5A held, sreq 0→1 with dbusy=0. Required response:
  - dvalid pulses once at the 4th edge with dout=30'h2A5_5A5A, and dack rises on the same edge.
  - After sreq falls, dack falls at the 3rd edge.
- Backpressure: dbusy=1 for 7 cycles during the transfer of 30'h3FFF_FFFF. No dvalid and no dack while busy; dvalid and dack rise on the first edge after dbusy=0, and there is exactly one pulse.
- Six back-to-back transfers, each din = {row i*3, kernel i} for i=0..5: exactly 6 pulses in order, each dout matching.
- Protocol violation: sreq dropped 2 cycles after sync detection while dbusy=1. The word is still delivered once, dack is high for exactly 1 cycle, and the FSM returns to IDLE.
- Reset asserted while in ACK: dack, dvalid and dout are 0 immediately. After release with sreq=0, idle=1, and the next transfer works normally.
